// File: rtl/icache_pkg.sv
// Shared types and helpers for the set-associative instruction cache.
package icache_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    // Byte offset width within a line
    function automatic int unsigned offset_w(input int unsigned line_bytes);
        return $unsigned($clog2(line_bytes));
    endfunction

    // Set index width
    function automatic int unsigned index_w(input int unsigned sets);
        return $unsigned($clog2(sets));
    endfunction

    // Tag width: whatever address bits remain above index and offset
    function automatic int unsigned tag_w(input int unsigned addr_w,
                                          input int unsigned line_bytes,
                                          input int unsigned sets);
        return addr_w - offset_w(line_bytes) - index_w(sets);
    endfunction

    // Word select width inside a line (32-bit words)
    function automatic int unsigned word_sel_w(input int unsigned line_bytes);
        return offset_w(line_bytes) - 2;
    endfunction

    // Way number width; a direct-mapped cache still carries one bit
    function automatic int unsigned way_w(input int unsigned ways);
        return (ways > 1) ? $unsigned($clog2(ways)) : 1;
    endfunction

    // Reverse byte order of a 32-bit word
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/icache_plru.sv
// Per-set pseudo-LRU replacement state with one update port and one victim read port.
module icache_plru
    import icache_pkg::*;
#(
    parameter int unsigned SETS = 32,
    parameter int unsigned WAYS = 2,
    localparam int unsigned INDEX_W = index_w(SETS),
    localparam int unsigned WAY_W   = way_w(WAYS),
    localparam int unsigned ST_W    = (WAYS == 4) ? 3 : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               upd_en,
    input  logic [INDEX_W-1:0] upd_set,
    input  logic [WAY_W-1:0]   upd_way,
    input  logic [INDEX_W-1:0] rd_set,
    output logic [WAY_W-1:0]   victim_c
);

    logic [ST_W-1:0] plru_q [SETS];
    logic [ST_W-1:0] row_c;
    logic [ST_W-1:0] row_d;

    assign row_c = plru_q[rd_set];

    if (WAYS == 4) begin : g_tree
        // Root bit picks the victim parity (even/odd ways); child bits pick within the pair.
        logic [ST_W-1:0] cur_c;
        assign cur_c = plru_q[upd_set];

        // Victim decode and MRU update for the 3-bit tree
        always_comb begin
            victim_c = row_c[0] ? {row_c[2], 1'b1} : {row_c[1], 1'b0};
            row_d    = cur_c;
            row_d[0] = ~upd_way[0];
            if (upd_way[0]) begin
                row_d[2] = ~upd_way[1];
            end else begin
                row_d[1] = ~upd_way[1];
            end
        end
    end else if (WAYS == 2) begin : g_bit
        // Single bit names the victim way
        always_comb begin
            victim_c = row_c;
            row_d    = ~upd_way;
        end
    end else begin : g_direct
        // Direct mapped: only way 0 exists
        always_comb begin
            victim_c = '0;
            row_d    = '0;
        end
    end

    // Replacement state: cleared on reset or flush, written on hit/fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(SETS); s++) plru_q[s] <= '0;
        end else if (clr) begin
            for (int s = 0; s < int'(SETS); s++) plru_q[s] <= '0;
        end else if (upd_en) begin
            plru_q[upd_set] <= row_d;
        end
    end

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache: combinational hit path, single outstanding line refill.
module icache_sa
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned SETS       = 32,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SWAP_BYTES = 1,
    localparam int unsigned LINE_W    = LINE_BYTES * 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic [31:0]       data_o,
    output logic              data_valid,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_data
);

    localparam int unsigned OFFSET_W = offset_w(LINE_BYTES);
    localparam int unsigned INDEX_W  = index_w(SETS);
    localparam int unsigned TAG_W    = tag_w(ADDR_W, LINE_BYTES, SETS);
    localparam int unsigned WSEL_W   = word_sel_w(LINE_BYTES);
    localparam int unsigned WAY_W    = way_w(WAYS);

    logic [TAG_W-1:0]   tag_mem  [WAYS][SETS];
    logic [LINE_W-1:0]  data_mem [WAYS][SETS];
    logic [WAYS-1:0]    valid_q  [SETS];

    state_e             state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               flush_pend_q, flush_pend_d;
    logic [INDEX_W-1:0] miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
    logic [WAY_W-1:0]   miss_way_q, miss_way_d;

    logic [INDEX_W-1:0] req_idx_c;
    logic [TAG_W-1:0]   req_tag_c;
    logic [WSEL_W-1:0]  req_wsel_c;
    logic               hit_c;
    logic [WAY_W-1:0]   hit_way_c;
    logic [WAY_W-1:0]   victim_c;
    logic [WAY_W-1:0]   plru_victim_c;
    logic [LINE_W-1:0]  line_c;
    logic [31:0]        word_c;
    logic               fill_we_c;
    logic               clear_all_c;
    logic               plru_upd_c;
    logic [INDEX_W-1:0] plru_set_c;
    logic [WAY_W-1:0]   plru_way_c;
    logic               unused_c;

    assign req_idx_c  = req_addr[OFFSET_W +: INDEX_W];
    assign req_tag_c  = req_addr[ADDR_W-1 -: TAG_W];
    assign req_wsel_c = req_addr[OFFSET_W-1:2];
    assign unused_c   = ^req_addr[1:0];

    // Tag compare across ways; lowest matching way wins
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[req_idx_c][w] && (tag_mem[w][req_idx_c] == req_tag_c)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way, else the replacement-state choice
    always_comb begin
        victim_c = plru_victim_c;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[req_idx_c][w]) victim_c = WAY_W'(w);
        end
    end

    assign line_c     = data_mem[hit_way_c][req_idx_c];
    assign word_c     = line_c[{req_wsel_c, 5'd0} +: 32];
    assign data_o     = (SWAP_BYTES != 0) ? bswap32(word_c) : word_c;
    assign data_valid = (state_q == IDLE) && req_valid && hit_c && !flush;
    assign busy       = req_valid && !data_valid;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

    // Next-state, refill handshake and array write strobes
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        flush_pend_d = flush_pend_q;
        miss_idx_d   = miss_idx_q;
        miss_tag_d   = miss_tag_q;
        miss_way_d   = miss_way_q;
        fill_we_c    = 1'b0;
        clear_all_c  = 1'b0;
        plru_upd_c   = 1'b0;
        plru_set_c   = req_idx_c;
        plru_way_c   = hit_way_c;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    clear_all_c = 1'b1;
                end else if (req_valid && hit_c) begin
                    plru_upd_c = 1'b1;
                end else if (req_valid) begin
                    miss_idx_d   = req_idx_c;
                    miss_tag_d   = req_tag_c;
                    miss_way_d   = victim_c;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = {req_tag_c, req_idx_c, OFFSET_W'(0)};
                    flush_pend_d = 1'b0;
                    state_d      = REFILL;
                end
            end
            REFILL: begin
                if (flush) flush_pend_d = 1'b1;
                if (mem_ack) begin
                    mem_req_d    = 1'b0;
                    flush_pend_d = 1'b0;
                    state_d      = IDLE;
                    if (flush_pend_q || flush) begin
                        clear_all_c = 1'b1;
                    end else begin
                        fill_we_c  = 1'b1;
                        plru_upd_c = 1'b1;
                        plru_set_c = miss_idx_q;
                        plru_way_c = miss_way_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            flush_pend_q <= 1'b0;
            miss_idx_q   <= '0;
            miss_tag_q   <= '0;
            miss_way_q   <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            flush_pend_q <= flush_pend_d;
            miss_idx_q   <= miss_idx_d;
            miss_tag_q   <= miss_tag_d;
            miss_way_q   <= miss_way_d;
        end
    end

    // Valid bits: cleared on reset/flush, set on fill
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int s = 0; s < int'(SETS); s++) valid_q[s] <= '0;
        end else if (clear_all_c) begin
            for (int s = 0; s < int'(SETS); s++) valid_q[s] <= '0;
        end else if (fill_we_c) begin
            valid_q[miss_idx_q][miss_way_q] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset
    always_ff @(posedge CLK) begin
        if (fill_we_c) begin
            data_mem[miss_way_q][miss_idx_q] <= mem_data;
            tag_mem[miss_way_q][miss_idx_q]  <= miss_tag_q;
        end
    end

    icache_plru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_plru (
        .clk      (CLK),
        .rst_n    (RST_N),
        .clr      (clear_all_c),
        .upd_en   (plru_upd_c),
        .upd_set  (plru_set_c),
        .upd_way  (plru_way_c),
        .rd_set   (req_idx_c),
        .victim_c (plru_victim_c)
    );

endmodule

// File: tb/tb_icache_sa.sv
// Testbench for icache_sa: a 2-way instance driven by directed and random fetches
// against an LRU line model, plus a 4-way instance for tree replacement order.
module tb_icache_sa;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         use4;
    logic         req_valid, flush, mem_ack;
    logic [31:0]  req_addr;
    logic [255:0] mem_data;

    logic [31:0] data_o2, data_o4, mem_addr2, mem_addr4;
    logic        dv2, dv4, busy2, busy4, mreq2, mreq4;
    logic [31:0] o_data, o_maddr;
    logic        o_dv, o_busy, o_mreq;

    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    assign o_data  = use4 ? data_o4   : data_o2;
    assign o_maddr = use4 ? mem_addr4 : mem_addr2;
    assign o_dv    = use4 ? dv4       : dv2;
    assign o_busy  = use4 ? busy4     : busy2;
    assign o_mreq  = use4 ? mreq4     : mreq2;

    icache_sa u_dut2 (
        .CLK(clk), .RST_N(rst_n),
        .req_valid(req_valid & ~use4), .req_addr(req_addr), .flush(flush & ~use4),
        .data_o(data_o2), .data_valid(dv2), .busy(busy2),
        .mem_req(mreq2), .mem_addr(mem_addr2),
        .mem_ack(mem_ack & ~use4), .mem_data(mem_data)
    );

    icache_sa #(.WAYS(4)) u_dut4 (
        .CLK(clk), .RST_N(rst_n),
        .req_valid(req_valid & use4), .req_addr(req_addr), .flush(flush & use4),
        .data_o(data_o4), .data_valid(dv4), .busy(busy4),
        .mem_req(mreq4), .mem_addr(mem_addr4),
        .mem_ack(mem_ack & use4), .mem_data(mem_data)
    );

    // Backing memory image
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h1122_3344;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  base;
        base = a & 32'hFFFF_FFE0;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = mem_word(base + 32'(4 * i));
        return l;
    endfunction

    function automatic logic [31:0] rev(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // One fetch; on a miss the memory acks `lat` cycles after mem_req rises.
    task automatic access(input logic [31:0] a, input int lat, output bit hit, output bit req_ok,
                          output logic [31:0] maddr, output bit dv, output logic [31:0] word);
        @(negedge clk); req_valid = 1'b1; req_addr = a; mem_ack = 1'b0; flush = 1'b0; #1;
        hit = o_dv; dv = o_dv; word = o_data; maddr = '0; req_ok = !o_mreq;
        if (!hit) begin
            req_ok = 1'b1;
            for (int k = 0; k <= lat; k++) begin
                @(negedge clk);
                if (k == lat) begin mem_ack = 1'b1; mem_data = line_of(o_maddr); end
                #1;
                if (k == 0) maddr = o_maddr;
                req_ok = req_ok & o_mreq & (o_maddr == maddr) & !o_dv;
            end
            @(negedge clk); mem_ack = 1'b0; #1;
            req_ok = req_ok & !o_mreq;
            dv = o_dv; word = o_data;
        end
    endtask

    task automatic flush_pulse();
        @(negedge clk); req_valid = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_addr = 32'h100;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (o_mreq !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", o_mreq); end
        n_checks++; if (o_maddr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", o_maddr); end
        n_checks++; if (o_dv !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b want 0", o_dv); end
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", o_busy); end
        @(negedge clk); rst_n = 1'b1; req_valid = 1'b0;
    endtask

    // Miss at cycle 0, mem_req at 1, ack at 4, hit data at 5
    task automatic test_first_fill();
        @(negedge clk); req_valid = 1'b1; req_addr = 32'h100; #1;
        n_checks++; if (o_dv !== 1'b0 || o_busy !== 1'b1 || o_mreq !== 1'b0) begin
            n_fail++; $display("FAIL fill_c0: dv=%b busy=%b mreq=%b want 0 1 0", o_dv, o_busy, o_mreq); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 4) begin mem_ack = 1'b1; mem_data = line_of(32'h100); end
            #1;
            n_checks++; if (o_mreq !== 1'b1 || o_maddr !== 32'h100 || o_dv !== 1'b0) begin
                n_fail++; $display("FAIL fill_c%0d: mreq=%b addr=%h dv=%b want 1 00000100 0", c, o_mreq, o_maddr, o_dv); end
        end
        @(negedge clk); mem_ack = 1'b0; #1;
        n_checks++; if (o_dv !== 1'b1 || o_data !== 32'h4433_2211 || o_mreq !== 1'b0) begin
            n_fail++; $display("FAIL fill_c5: dv=%b data=%h mreq=%b want 1 44332211 0", o_dv, o_data, o_mreq); end
    endtask

    task automatic test_line_hits();
        logic [31:0] a;
        for (int i = 1; i < 8; i++) begin
            a = 32'h100 + 32'(4 * i);
            @(negedge clk); req_valid = 1'b1; req_addr = a; #1;
            n_checks++; if (o_dv !== 1'b1 || o_data !== rev(mem_word(a)) || o_mreq !== 1'b0) begin
                n_fail++; $display("FAIL line_hit %h: dv=%b data=%h mreq=%b want 1 %h 0", a, o_dv, o_data, o_mreq, rev(mem_word(a))); end
        end
    endtask

    task automatic test_evict();
        bit hit, rok, dv; logic [31:0] ma, w;
        flush_pulse();
        access(32'h000, 2, hit, rok, ma, dv, w);
        access(32'h400, 1, hit, rok, ma, dv, w);
        access(32'h000, 0, hit, rok, ma, dv, w);
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL evict_rehit0: hit=%b want 1", hit); end
        access(32'h800, 1, hit, rok, ma, dv, w);
        n_checks++; if (hit !== 1'b0 || ma !== 32'h800) begin n_fail++; $display("FAIL evict_miss800: hit=%b addr=%h want 0 00000800", hit, ma); end
        access(32'h000, 1, hit, rok, ma, dv, w);
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL evict_hit0: hit=%b want 1", hit); end
        access(32'h400, 1, hit, rok, ma, dv, w);
        n_checks++; if (hit !== 1'b0 || ma !== 32'h400 || rok !== 1'b1) begin
            n_fail++; $display("FAIL evict_miss400: hit=%b addr=%h req_ok=%b want 0 00000400 1", hit, ma, rok); end
    endtask

    task automatic test_flush_refill();
        bit hit, rok, dv; logic [31:0] ma, w;
        flush_pulse();
        access(32'h000, 1, hit, rok, ma, dv, w);
        @(negedge clk); req_valid = 1'b1; req_addr = 32'h200;
        @(negedge clk); req_valid = 1'b0; flush = 1'b1; #1;
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (o_mreq !== 1'b1 || o_maddr !== 32'h200) begin
                n_fail++; $display("FAIL flush_refill_hold%0d: mreq=%b addr=%h want 1 00000200", c, o_mreq, o_maddr); end
            @(negedge clk); flush = 1'b0;
            if (c == 2) begin mem_ack = 1'b1; mem_data = line_of(32'h200); end
            #1;
        end
        @(negedge clk); mem_ack = 1'b0; #1;
        n_checks++; if (o_mreq !== 1'b0) begin n_fail++; $display("FAIL flush_refill_drop: mreq=%b want 0", o_mreq); end
        access(32'h200, 1, hit, rok, ma, dv, w);
        n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL flush_no_install: hit=%b want 0", hit); end
        access(32'h000, 1, hit, rok, ma, dv, w);
        n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL flush_old_line: hit=%b want 0", hit); end
    endtask

    task automatic test_reset_mid_refill();
        bit hit, rok, dv; logic [31:0] ma, w;
        @(negedge clk); req_valid = 1'b1; req_addr = 32'h100;
        @(negedge clk); #1;
        n_checks++; if (o_mreq !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: mreq=%b want 1", o_mreq); end
        #2 rst_n = 1'b0; #1;
        n_checks++; if (o_mreq !== 1'b0 || o_maddr !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_async: mreq=%b addr=%h want 0 00000000", o_mreq, o_maddr); end
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        access(32'h000, 0, hit, rok, ma, dv, w);
        n_checks++; if (hit !== 1'b0 || dv !== 1'b1 || w !== rev(mem_word(32'h000))) begin
            n_fail++; $display("FAIL rst_mid_miss0: hit=%b dv=%b data=%h want 0 1 %h", hit, dv, w, rev(mem_word(32'h000))); end
        access(32'h100, 0, hit, rok, ma, dv, w);
        n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL rst_mid_miss100: hit=%b want 0", hit); end
    endtask

    task automatic test_addr_change();
        @(negedge clk); req_valid = 1'b1; req_addr = 32'h200;
        @(negedge clk); req_addr = 32'h300; #1;
        n_checks++; if (o_mreq !== 1'b1 || o_maddr !== 32'h200) begin
            n_fail++; $display("FAIL addr_chg_req: mreq=%b addr=%h want 1 00000200", o_mreq, o_maddr); end
        @(negedge clk); mem_ack = 1'b1; mem_data = line_of(32'h200);
        @(negedge clk); mem_ack = 1'b0; #1;
        n_checks++; if (o_dv !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL addr_chg_300_miss: dv=%b busy=%b want 0 1", o_dv, o_busy); end
        @(negedge clk); #1;
        n_checks++; if (o_mreq !== 1'b1 || o_maddr !== 32'h300) begin
            n_fail++; $display("FAIL addr_chg_req300: mreq=%b addr=%h want 1 00000300", o_mreq, o_maddr); end
        @(negedge clk); mem_ack = 1'b1; mem_data = line_of(32'h300);
        @(negedge clk); mem_ack = 1'b0; req_addr = 32'h208; #1;
        n_checks++; if (o_dv !== 1'b1 || o_data !== rev(mem_word(32'h208))) begin
            n_fail++; $display("FAIL addr_chg_200_installed: dv=%b data=%h want 1 %h", o_dv, o_data, rev(mem_word(32'h208))); end
    endtask

    // Random fetches against a per-set LRU model of resident lines (2 ways)
    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] a, line, ma, w;
        bit hit, rok, dv, exp_hit;
        int cnt, oldest;
        flush_pulse();
        for (int it = 0; it < 80; it++) begin
            line = 32'($urandom_range(0, 3)) * 32'h400 + (($urandom_range(0, 1) == 1) ? 32'h0A0 : 32'h0);
            a = line + 32'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk); req_valid = 1'b1; req_addr = a; flush = 1'b1; #1;
                n_checks++; if (o_dv !== 1'b0) begin n_fail++; $display("FAIL rnd_flush_dv: dv=%b want 0", o_dv); end
                @(negedge clk); req_valid = 1'b0; flush = 1'b0; #1;
                n_checks++; if (o_mreq !== 1'b0) begin n_fail++; $display("FAIL rnd_flush_noreq: mreq=%b want 0", o_mreq); end
                q.delete();
                continue;
            end
            exp_hit = 1'b0;
            foreach (q[i]) if (q[i] == line) exp_hit = 1'b1;
            access(a, int'($urandom_range(0, 3)), hit, rok, ma, dv, w);
            n_checks++; if (hit !== exp_hit) begin n_fail++; $display("FAIL rnd_hit %h: hit=%b want %b", a, hit, exp_hit); end
            n_checks++; if (dv !== 1'b1 || w !== rev(mem_word(a)) || rok !== 1'b1) begin
                n_fail++; $display("FAIL rnd_data %h: dv=%b data=%h req_ok=%b want 1 %h 1", a, dv, w, rok, rev(mem_word(a))); end
            if (!exp_hit) begin
                n_checks++; if (ma !== line) begin n_fail++; $display("FAIL rnd_mem_addr: got %h want %h", ma, line); end
            end
            if (exp_hit) begin
                for (int i = 0; i < q.size(); i++) if (q[i] == line) begin q.delete(i); break; end
            end else begin
                cnt = 0; oldest = -1;
                foreach (q[i]) if (q[i][9:5] == line[9:5]) begin cnt++; if (oldest < 0) oldest = i; end
                if (cnt >= 2) q.delete(oldest);
            end
            q.push_back(line);
        end
    endtask

    // 4-way: A,B,C,D fill, A hit, E replaces B
    task automatic test_plru4();
        bit hit, rok, dv; logic [31:0] ma, w;
        @(negedge clk); req_valid = 1'b0; use4 = 1'b1;
        flush_pulse();
        access(32'h0000, 1, hit, rok, ma, dv, w);
        access(32'h0400, 1, hit, rok, ma, dv, w);
        access(32'h0800, 1, hit, rok, ma, dv, w);
        access(32'h0C00, 1, hit, rok, ma, dv, w);
        access(32'h0004, 1, hit, rok, ma, dv, w);
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL plru4_A_hit: hit=%b want 1", hit); end
        access(32'h1000, 1, hit, rok, ma, dv, w);
        n_checks++; if (hit !== 1'b0 || ma !== 32'h1000) begin n_fail++; $display("FAIL plru4_E_miss: hit=%b addr=%h want 0 00001000", hit, ma); end
        access(32'h0008, 1, hit, rok, ma, dv, w);
        n_checks++; if (hit !== 1'b1 || w !== rev(mem_word(32'h0008))) begin
            n_fail++; $display("FAIL plru4_A_kept: hit=%b data=%h want 1 %h", hit, w, rev(mem_word(32'h0008))); end
        access(32'h0808, 1, hit, rok, ma, dv, w);
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL plru4_C_kept: hit=%b want 1", hit); end
        access(32'h0C08, 1, hit, rok, ma, dv, w);
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL plru4_D_kept: hit=%b want 1", hit); end
        access(32'h0400, 1, hit, rok, ma, dv, w);
        n_checks++; if (hit !== 1'b0 || ma !== 32'h0400) begin n_fail++; $display("FAIL plru4_B_evicted: hit=%b addr=%h want 0 00000400", hit, ma); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0; n_fail = 0; use4 = 1'b0;
        req_valid = 1'b0; req_addr = '0; flush = 1'b0; mem_ack = 1'b0; mem_data = '0; rst_n = 1'b0;
        test_reset();
        test_first_fill();
        test_line_hits();
        test_evict();
        test_flush_refill();
        test_reset_mid_refill();
        test_addr_change();
        test_random();
        test_plru4();
        @(negedge clk); req_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
